// File: rtl/aib_pkg.sv
// Shared beat field positions, receive FSM states and the per-word parity helper
// for the AIB receive framing layer.
package aib_pkg;

  localparam int BEAT_W   = 40;
  localparam int WORD_W   = 72;
  localparam int MARK_BIT = 39;
  localparam int VLD_BIT  = 38;
  localparam int PAR_MSB  = 37;
  localparam int PAR_LSB  = 34;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } aib_rx_state_e;

  // Even parity over four 18-bit slices of the reassembled word.
  function automatic logic [3:0] aib_parity(input logic [WORD_W-1:0] word);
    logic [3:0] p;
    for (int k = 0; k < 4; k++) begin
      p[k] = ^word[18*k +: 18];
    end
    return p;
  endfunction

endpackage

// File: rtl/aib_rx_fifo.sv
// Synchronous word FIFO with pointer-based full/empty, a flop-array read port and
// an overflow indication for pushes that cannot be accepted.
module aib_rx_fifo #(
  parameter int DATA_W = 72,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              empty, full, do_push, do_pop;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop  = i_pop && !empty;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    do_push = i_push && (!full || do_pop);
    o_drop  = i_push && full && !do_pop;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    o_valid = !empty;
    o_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/aib_rx_deframer.sv
// AIB receive deframer: locks onto the 2-beat frame, checks parity, reassembles
// 72-bit words into a FIFO and returns one credit per word consumed.
module aib_rx_deframer
  import aib_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LOCK_CNT   = 8,
  parameter int ERR_LIMIT  = 4
) (
  input  logic        i_aib_clk,
  input  logic        i_rst,
  input  logic [19:0] i_rx_data0,
  input  logic [19:0] i_rx_data1,
  input  logic        i_clr_sticky,
  output logic        o_rx_valid,
  input  logic        i_rx_ready,
  output logic [71:0] o_rx_data,
  output logic        o_credit_return,
  output logic        o_lock,
  output logic        o_parity_err,
  output logic        o_overflow,
  output logic [7:0]  o_err_cnt
);

  localparam logic [7:0] LOCK_CNT_C  = 8'(LOCK_CNT);
  localparam logic [3:0] ERR_LIMIT_C = 4'(ERR_LIMIT);

  aib_rx_state_e     state_q, state_d;
  logic              exp_b1_q, exp_b1_d;
  logic [7:0]        pair_cnt_q, pair_cnt_d;
  logic [3:0]        cerr_q, cerr_d;
  logic [37:0]       b0_q, b0_d;
  logic              b0_ok_q, b0_ok_d;
  logic              par_err_q, par_err_d;
  logic              credit_q, credit_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic [BEAT_W-1:0] beat;
  logic [WORD_W-1:0] word;
  logic              mark, mark_ok, par_ok, push, pop, frame_err, fifo_drop;

  always_comb begin
    beat    = {i_rx_data1, i_rx_data0};
    mark    = beat[MARK_BIT];
    mark_ok = (mark == !exp_b1_q);
    word    = {beat[33:0], b0_q};
    par_ok  = (aib_parity(word) == beat[PAR_MSB:PAR_LSB]);
    pop     = o_rx_valid && i_rx_ready;

    state_d    = state_q;
    exp_b1_d   = !exp_b1_q;
    pair_cnt_d = pair_cnt_q;
    cerr_d     = cerr_q;
    b0_d       = b0_q;
    b0_ok_d    = b0_ok_q;
    push       = 1'b0;
    par_err_d  = 1'b0;
    frame_err  = 1'b0;

    unique case (state_q)
      HUNT: begin
        exp_b1_d = mark;
        b0_ok_d  = 1'b0;
        if (mark) begin
          state_d    = VERIFY;
          pair_cnt_d = '0;
        end
      end
      VERIFY: begin
        if (!mark_ok) begin
          state_d = HUNT;
        end else if (exp_b1_q) begin
          pair_cnt_d = pair_cnt_q + 8'd1;
          if (pair_cnt_q + 8'd1 == LOCK_CNT_C) begin
            state_d = LOCKED;
            cerr_d  = '0;
            b0_ok_d = 1'b0;
          end
        end
      end
      LOCKED: begin
        if (mark_ok) begin
          cerr_d = '0;
          if (!exp_b1_q) begin
            b0_d    = beat[37:0];
            b0_ok_d = beat[VLD_BIT];
          end else begin
            b0_ok_d = 1'b0;
            if (b0_ok_q) begin
              push      = par_ok;
              par_err_d = !par_ok;
            end
          end
        end else begin
          // A broken frame discards whatever half-word is being assembled.
          cerr_d    = cerr_q + 4'd1;
          frame_err = 1'b1;
          b0_ok_d   = 1'b0;
          if (cerr_q + 4'd1 == ERR_LIMIT_C) begin
            state_d = HUNT;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    credit_d = pop;
    if (i_clr_sticky) begin
      overflow_d = 1'b0;
      err_cnt_d  = '0;
    end else begin
      overflow_d = overflow_q | fifo_drop;
      err_cnt_d  = ((par_err_d || frame_err) && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end
  end

  always_ff @(posedge i_aib_clk) begin
    if (i_rst) begin
      state_q    <= HUNT;
      exp_b1_q   <= 1'b0;
      pair_cnt_q <= '0;
      cerr_q     <= '0;
      b0_ok_q    <= 1'b0;
      par_err_q  <= 1'b0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      exp_b1_q   <= exp_b1_d;
      pair_cnt_q <= pair_cnt_d;
      cerr_q     <= cerr_d;
      b0_ok_q    <= b0_ok_d;
      par_err_q  <= par_err_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_ff @(posedge i_aib_clk) begin
    b0_q <= b0_d;
  end

  aib_rx_fifo #(
    .DATA_W (WORD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_aib_clk),
    .rst     (i_rst),
    .i_push  (push),
    .i_data  (word),
    .i_pop   (pop),
    .o_valid (o_rx_valid),
    .o_data  (o_rx_data),
    .o_drop  (fifo_drop)
  );

  assign o_credit_return = credit_q;
  assign o_lock          = (state_q == LOCKED);
  assign o_parity_err    = par_err_q;
  assign o_overflow      = overflow_q;
  assign o_err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_aib_rx_deframer.sv
// Directed bench for aib_rx_deframer: lock-up, word delivery, overflow, parity,
// loss of lock and mid-operation reset, with hand-derived expectations.
module tb_aib_rx_deframer;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [19:0] i_rx_data0 = '0;
  logic [19:0] i_rx_data1 = '0;
  logic        i_clr_sticky = 1'b0;
  logic        i_rx_ready = 1'b0;
  logic        o_rx_valid;
  logic [71:0] o_rx_data;
  logic        o_credit_return;
  logic        o_lock;
  logic        o_parity_err;
  logic        o_overflow;
  logic [7:0]  o_err_cnt;

  int total = 0;
  int bad = 0;
  int credit_cnt = 0;

  localparam logic [39:0] IDLE0 = {1'b1, 1'b0, 38'h0};
  localparam logic [39:0] IDLE1 = 40'h0;
  localparam logic [71:0] W_MAIN = 72'h12_3456_789A_BCDE_F012;

  aib_rx_deframer dut (
    .i_aib_clk       (clk),
    .i_rst           (i_rst),
    .i_rx_data0      (i_rx_data0),
    .i_rx_data1      (i_rx_data1),
    .i_clr_sticky    (i_clr_sticky),
    .o_rx_valid      (o_rx_valid),
    .i_rx_ready      (i_rx_ready),
    .o_rx_data       (o_rx_data),
    .o_credit_return (o_credit_return),
    .o_lock          (o_lock),
    .o_parity_err    (o_parity_err),
    .o_overflow      (o_overflow),
    .o_err_cnt       (o_err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_credit_return === 1'b1) credit_cnt++;
  end

  function automatic logic [3:0] par_of(input logic [71:0] w);
    logic [3:0] p;
    p = '0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 18; j++)
        p[k] = p[k] ^ w[18*k + j];
    return p;
  endfunction

  function automatic logic [71:0] wd(input int i);
    return {8'(8'hC0 + i), 64'h0123_4567_89AB_CDE0 + 64'(i)};
  endfunction

  // Present one beat; returns 1 time unit after the edge that sampled it.
  task automatic drive(input logic [39:0] b);
    i_rx_data0 = b[19:0];
    i_rx_data1 = b[39:20];
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [71:0] w);
    drive({1'b1, 1'b1, w[37:0]});
    drive({1'b0, 1'b1, par_of(w), w[71:38]});
  endtask

  task automatic idle_pair();
    drive(IDLE0);
    drive(IDLE1);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (o_lock !== 1'b0) begin bad++; $display("FAIL reset_lock: got=%0b want=0", o_lock); end
    total++; if (o_rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%0b want=0", o_rx_valid); end
    total++; if (o_err_cnt !== 8'd0) begin bad++; $display("FAIL reset_errcnt: got=%0d want=0", o_err_cnt); end
    total++; if ({o_overflow, o_parity_err, o_credit_return} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got=%b want=000", {o_overflow, o_parity_err, o_credit_return});
    end
    total++; if (o_rx_data !== 72'h0) begin bad++; $display("FAIL reset_data: got=%h want=0", o_rx_data); end
  endtask

  task automatic test_lock();
    for (int p = 1; p <= 20; p++) begin
      idle_pair();
      if (p == 7) begin
        total++; if (o_lock !== 1'b0) begin bad++; $display("FAIL lock_pair7: got=%0b want=0", o_lock); end
      end
      if (p == 8) begin
        total++; if (o_lock !== 1'b1) begin bad++; $display("FAIL lock_pair8: got=%0b want=1", o_lock); end
      end
    end
    total++; if (o_lock !== 1'b1) begin bad++; $display("FAIL lock_pair20: got=%0b want=1", o_lock); end
    total++; if (o_rx_valid !== 1'b0) begin bad++; $display("FAIL lock_no_words: got=%0b want=0", o_rx_valid); end
  endtask

  task automatic test_single_word();
    int c0;
    i_rx_ready = 1'b0;
    send_word(W_MAIN);
    total++; if (o_rx_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got=%0b want=1", o_rx_valid); end
    total++; if (o_rx_data !== W_MAIN) begin bad++; $display("FAIL single_data: got=%h want=%h", o_rx_data, W_MAIN); end
    total++; if (o_credit_return !== 1'b0) begin bad++; $display("FAIL single_no_early_credit: got=%0b want=0", o_credit_return); end
    c0 = credit_cnt;
    i_rx_ready = 1'b1;
    drive(IDLE0);
    total++; if (o_credit_return !== 1'b1) begin bad++; $display("FAIL single_credit: got=%0b want=1", o_credit_return); end
    total++; if (o_rx_valid !== 1'b0) begin bad++; $display("FAIL single_popped: got=%0b want=0", o_rx_valid); end
    i_rx_ready = 1'b0;
    drive(IDLE1);
    idle_pair();
    total++; if (credit_cnt - c0 !== 1) begin bad++; $display("FAIL single_credit_count: got=%0d want=1", credit_cnt - c0); end
  endtask

  task automatic test_overflow();
    int c0;
    i_rx_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_word(wd(i));
    total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL ovf_before9: got=%0b want=0", o_overflow); end
    send_word(wd(8));
    total++; if (o_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got=%0b want=1", o_overflow); end
    total++; if (o_rx_data !== wd(0)) begin bad++; $display("FAIL ovf_head_stable: got=%h want=%h", o_rx_data, wd(0)); end
    c0 = credit_cnt;
    i_rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if (o_rx_valid !== 1'b1 || o_rx_data !== wd(i)) begin
        bad++; $display("FAIL drain_word%0d: got=%0b/%h want=1/%h", i, o_rx_valid, o_rx_data, wd(i));
      end
      drive((i % 2 == 0) ? IDLE0 : IDLE1);
    end
    i_rx_ready = 1'b0;
    total++; if (o_rx_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got=%0b want=0", o_rx_valid); end
    idle_pair();
    total++; if (credit_cnt - c0 !== 8) begin bad++; $display("FAIL drain_credits: got=%0d want=8", credit_cnt - c0); end
  endtask

  task automatic test_parity();
    logic [71:0] wf;
    wf = W_MAIN ^ (72'h1 << 40);
    drive({1'b1, 1'b1, W_MAIN[37:0]});
    drive({1'b0, 1'b1, par_of(W_MAIN), wf[71:38]});
    total++; if (o_parity_err !== 1'b1) begin bad++; $display("FAIL par_pulse: got=%0b want=1", o_parity_err); end
    total++; if (o_err_cnt !== 8'd1) begin bad++; $display("FAIL par_errcnt: got=%0d want=1", o_err_cnt); end
    total++; if (o_rx_valid !== 1'b0) begin bad++; $display("FAIL par_no_word: got=%0b want=0", o_rx_valid); end
    drive(IDLE0);
    total++; if (o_parity_err !== 1'b0) begin bad++; $display("FAIL par_pulse_end: got=%0b want=0", o_parity_err); end
    i_clr_sticky = 1'b1;
    drive(IDLE1);
    i_clr_sticky = 1'b0;
    total++; if (o_err_cnt !== 8'd0 || o_overflow !== 1'b0) begin
      bad++; $display("FAIL clr_sticky: got=%0d/%0b want=0/0", o_err_cnt, o_overflow);
    end
  endtask

  task automatic test_unlock();
    int c0;
    i_rx_ready = 1'b0;
    send_word(wd(20));
    send_word(wd(21));
    // Three beats with the wrong mark, then a correct beat1.
    drive(IDLE1);
    drive(IDLE0);
    drive(IDLE1);
    drive(IDLE1);
    total++; if (o_lock !== 1'b1) begin bad++; $display("FAIL three_bad_locked: got=%0b want=1", o_lock); end
    total++; if (o_err_cnt !== 8'd3) begin bad++; $display("FAIL three_bad_errcnt: got=%0d want=3", o_err_cnt); end
    drive(IDLE1);
    drive(IDLE0);
    drive(IDLE1);
    total++; if (o_lock !== 1'b1) begin bad++; $display("FAIL unlock_after3: got=%0b want=1", o_lock); end
    drive(IDLE0);
    total++; if (o_lock !== 1'b0) begin bad++; $display("FAIL unlock_after4: got=%0b want=0", o_lock); end
    total++; if (o_err_cnt !== 8'd7) begin bad++; $display("FAIL unlock_errcnt: got=%0d want=7", o_err_cnt); end
    c0 = credit_cnt;
    i_rx_ready = 1'b1;
    total++; if (o_rx_valid !== 1'b1 || o_rx_data !== wd(20)) begin
      bad++; $display("FAIL unlock_drain0: got=%0b/%h want=1/%h", o_rx_valid, o_rx_data, wd(20));
    end
    drive(IDLE0);
    total++; if (o_rx_valid !== 1'b1 || o_rx_data !== wd(21)) begin
      bad++; $display("FAIL unlock_drain1: got=%0b/%h want=1/%h", o_rx_valid, o_rx_data, wd(21));
    end
    drive(IDLE1);
    i_rx_ready = 1'b0;
    total++; if (o_rx_valid !== 1'b0) begin bad++; $display("FAIL unlock_empty: got=%0b want=0", o_rx_valid); end
    idle_pair();
    total++; if (credit_cnt - c0 !== 2) begin bad++; $display("FAIL unlock_credits: got=%0d want=2", credit_cnt - c0); end
  endtask

  task automatic test_mid_reset();
    int c0;
    do_reset();
    for (int p = 0; p < 8; p++) idle_pair();
    total++; if (o_lock !== 1'b1) begin bad++; $display("FAIL relock: got=%0b want=1", o_lock); end
    i_rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_word(wd(30 + i));
    total++; if (o_rx_valid !== 1'b1) begin bad++; $display("FAIL rst_buffered: got=%0b want=1", o_rx_valid); end
    c0 = credit_cnt;
    i_rx_ready = 1'b1;
    i_rst = 1'b1;
    drive(IDLE0);
    i_rst = 1'b0;
    total++; if (o_rx_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got=%0b want=0", o_rx_valid); end
    total++; if (o_lock !== 1'b0) begin bad++; $display("FAIL rst_lock: got=%0b want=0", o_lock); end
    total++; if (o_credit_return !== 1'b0) begin bad++; $display("FAIL rst_credit: got=%0b want=0", o_credit_return); end
    drive(IDLE1);
    idle_pair();
    idle_pair();
    total++; if (credit_cnt - c0 !== 0) begin bad++; $display("FAIL rst_no_credits: got=%0d want=0", credit_cnt - c0); end
    total++; if (o_rx_valid !== 1'b0) begin bad++; $display("FAIL rst_stays_empty: got=%0b want=0", o_rx_valid); end
    i_rx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_word();
    test_overflow();
    test_parity();
    test_unlock();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
